// File: rtl/dcfifo_pkg.sv
// Shared constants and width helpers for the dcfifo block.
package dcfifo_pkg;

  localparam string DCFIFO_ON    = "ON";
  localparam string DCFIFO_OFF   = "OFF";
  localparam string DCFIFO_TRUE  = "TRUE";
  localparam string DCFIFO_FALSE = "FALSE";

  // Ceiling log2; used for the default usedw width.
  function automatic int unsigned dcfifo_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

  // The internal occupancy counter needs one extra bit so "full" is distinct from "empty".
  function automatic int unsigned dcfifo_cnt_w(input int unsigned usedw_w);
    return usedw_w + 1;
  endfunction

endpackage

// File: rtl/dcfifo_if.sv
// Write/read request and status bundle between a FIFO user and dcfifo.
interface dcfifo_if #(
  parameter int unsigned LPM_WIDTH  = 132,
  parameter int unsigned LPM_WIDTHU = 10
);

  logic [LPM_WIDTH-1:0]  data;
  logic                  wrreq;
  logic                  rdreq;
  logic [LPM_WIDTH-1:0]  q;
  logic                  rdempty;
  logic                  wrempty;
  logic                  wrfull;
  logic                  rdfull;
  logic                  wrpfull;
  logic                  wroverflow;
  logic [LPM_WIDTHU-1:0] wrusedw;
  logic [LPM_WIDTHU-1:0] rdusedw;

  modport master (
    output data, wrreq, rdreq,
    input  q, rdempty, wrempty, wrfull, rdfull, wrpfull, wroverflow, wrusedw, rdusedw
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, rdempty, wrempty, wrfull, rdfull, wrpfull, wroverflow, wrusedw, rdusedw
  );

endinterface

// File: rtl/dcfifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port (write-first on address collision).
module dcfifo_ram #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned WIDTH = 132,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [WORDS];
  logic [WIDTH-1:0] r_rdata;
  logic             w_collide;

  assign w_collide = i_we && (i_waddr == i_raddr);

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Collision forwards the incoming word so a just-written head is visible immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_collide ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dcfifo.sv
// Single-clock FIFO with dcfifo-compatible parameters, flags and showahead/normal read modes.
// Define DCFIFO_ASSERT_EN to compile simulation checks for write-while-full, read-while-empty and count overrun.
module dcfifo
  import dcfifo_pkg::*;
#(
  parameter string       ENABLE_ECC             = "FALSE",
  parameter string       INTENDED_DEVICE_FAMILY = "Agilex",
  parameter string       FIFO_TYPE              = "M20K",
  parameter int unsigned LPM_NUM_WORDS          = 1024,
  parameter string       LPM_SHOWAHEAD          = "ON",
  parameter string       LPM_TYPE               = "dcfifo",
  parameter int unsigned LPM_WIDTH              = 132,
  parameter int unsigned LPM_THRESH             = 800,
  parameter int unsigned LPM_WIDTHU             = dcfifo_clog2(LPM_NUM_WORDS),
  parameter string       OVERFLOW_CHECKING      = "ON",
  parameter string       UNDERFLOW_CHECKING     = "ON",
  parameter string       USE_EAB                = "ON",
  parameter int unsigned RDSYNC_DELAYPIPE       = 4,
  parameter int unsigned WRSYNC_DELAYPIPE       = 4
) (
  input  logic    clk,
  input  logic    aclr,
  dcfifo_if.slave bus
);

  localparam int unsigned AW        = LPM_WIDTHU;
  localparam int unsigned CW        = dcfifo_cnt_w(LPM_WIDTHU);
  localparam bit          SHOWAHEAD = (LPM_SHOWAHEAD != DCFIFO_OFF);
  localparam bit          OVF_CHK   = (OVERFLOW_CHECKING != DCFIFO_OFF);
  localparam bit          UNF_CHK   = (UNDERFLOW_CHECKING != DCFIFO_OFF);
  localparam logic [CW-1:0] DEPTH_C  = CW'(LPM_NUM_WORDS);
  localparam logic [CW-1:0] THRESH_C = CW'(LPM_THRESH);

  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_pfull;
  logic                 r_ovf;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [CW-1:0]        w_count_nxt;
  logic [AW-1:0]        w_rptr_inc;
  logic [AW-1:0]        w_raddr;
  logic                 w_re;
  logic                 w_we;
  logic [LPM_WIDTH-1:0] w_ram_q;
  logic                 w_unused_cfg;

  // Device/ECC/sync-pipe settings are accepted for compatibility only.
  assign w_unused_cfg = (ENABLE_ECC == DCFIFO_TRUE) ^ (ENABLE_ECC == DCFIFO_FALSE)
                      ^ (INTENDED_DEVICE_FAMILY == "") ^ (FIFO_TYPE == "")
                      ^ (LPM_TYPE == "") ^ (USE_EAB == DCFIFO_ON)
                      ^ (RDSYNC_DELAYPIPE == WRSYNC_DELAYPIPE);

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_wr_ok     = bus.wrreq && (!w_full  || !OVF_CHK);
  assign w_rd_ok     = bus.rdreq && (!w_empty || !UNF_CHK);
  assign w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
  assign w_rptr_inc  = r_rptr + AW'(1);
  assign w_we        = w_wr_ok && !aclr;

  // Showahead keeps the read register tracking the post-edge head; normal mode loads only on a pop.
  assign w_raddr = (SHOWAHEAD && w_rd_ok) ? w_rptr_inc : r_rptr;
  assign w_re    = SHOWAHEAD ? 1'b1 : w_rd_ok;

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_pfull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rptr <= w_rptr_inc;
      end
      r_count <= w_count_nxt;
      r_pfull <= (w_count_nxt >= THRESH_C);
      r_ovf   <= bus.wrreq && w_full;
    end
  end

  dcfifo_ram #(
    .WORDS (LPM_NUM_WORDS),
    .WIDTH (LPM_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (aclr),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (bus.data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  assign bus.q          = w_ram_q;
  assign bus.rdempty    = w_empty;
  assign bus.wrempty    = w_empty;
  assign bus.wrfull     = w_full;
  assign bus.rdfull     = w_full;
  assign bus.wrpfull    = r_pfull;
  assign bus.wroverflow = r_ovf;
  assign bus.wrusedw    = r_count[AW-1:0];
  assign bus.rdusedw    = r_count[AW-1:0];

`ifdef DCFIFO_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!aclr) begin
      if (bus.wrreq && w_full) begin
        $error("dcfifo: write request while full");
      end
      if (bus.rdreq && w_empty) begin
        $error("dcfifo: read request while empty");
      end
      if (r_count > DEPTH_C) begin
        $error("dcfifo: count exceeds depth");
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcfifo.sv
// Randomized and directed bench for dcfifo in showahead and normal modes against a queue model.
module tb_dcfifo;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned WIDTH  = 12;
  localparam int unsigned WU     = 8;
  localparam int unsigned THRESH = 100;

  logic clk;
  logic aclr;

  dcfifo_if #(.LPM_WIDTH(WIDTH), .LPM_WIDTHU(WU)) bus_sa ();
  dcfifo_if #(.LPM_WIDTH(WIDTH), .LPM_WIDTHU(WU)) bus_nr ();

  dcfifo #(
    .LPM_NUM_WORDS (DEPTH), .LPM_WIDTH (WIDTH), .LPM_THRESH (THRESH),
    .LPM_WIDTHU (WU), .LPM_SHOWAHEAD ("ON")
  ) u_dut_sa (.clk(clk), .aclr(aclr), .bus(bus_sa));

  dcfifo #(
    .LPM_NUM_WORDS (DEPTH), .LPM_WIDTH (WIDTH), .LPM_THRESH (THRESH),
    .LPM_WIDTHU (WU), .LPM_SHOWAHEAD ("OFF")
  ) u_dut_nr (.clk(clk), .aclr(aclr), .bus(bus_nr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents as a queue plus the registered side flags.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_q_nr;
  logic             m_pfull;
  logic             m_ovf;
  logic             just_rst;
  int unsigned      n_checks;
  int unsigned      n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_dut(input string p, input logic re, input logic we, input logic wf,
                         input logic rf, input logic pf, input logic ov,
                         input logic [WU-1:0] wu, input logic [WU-1:0] ru, input int unsigned n);
    chk({p, "_rdempty"},    32'(re), 32'(n == 0));
    chk({p, "_wrempty"},    32'(we), 32'(n == 0));
    chk({p, "_wrfull"},     32'(wf), 32'(n == DEPTH));
    chk({p, "_rdfull"},     32'(rf), 32'(n == DEPTH));
    chk({p, "_wrpfull"},    32'(pf), 32'(m_pfull));
    chk({p, "_wroverflow"}, 32'(ov), 32'(m_ovf));
    chk({p, "_wrusedw"},    32'(wu), n % DEPTH);
    chk({p, "_rdusedw"},    32'(ru), n % DEPTH);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bus_sa.wrreq = wr; bus_sa.rdreq = rd; bus_sa.data = d;
    bus_nr.wrreq = wr; bus_nr.rdreq = rd; bus_nr.data = d;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    int unsigned n;
    drive(wr, rd, d);
    @(negedge clk);
    n = mq.size();
    chk_dut("sa", bus_sa.rdempty, bus_sa.wrempty, bus_sa.wrfull, bus_sa.rdfull,
            bus_sa.wrpfull, bus_sa.wroverflow, bus_sa.wrusedw, bus_sa.rdusedw, n);
    chk_dut("nr", bus_nr.rdempty, bus_nr.wrempty, bus_nr.wrfull, bus_nr.rdfull,
            bus_nr.wrpfull, bus_nr.wroverflow, bus_nr.wrusedw, bus_nr.rdusedw, n);
    if (n > 0) begin
      chk("sa_q_head", 32'(bus_sa.q), 32'(mq[0]));
    end else if (just_rst) begin
      chk("sa_q_reset", 32'(bus_sa.q), 32'd0);
    end
    chk("nr_q", 32'(bus_nr.q), 32'(m_q_nr));
    just_rst = 1'b0;
    @(posedge clk);
    m_ovf = wr && (n == DEPTH);
    if (rd && n > 0) begin
      m_q_nr = mq.pop_front();
    end
    if (wr && n < DEPTH) begin
      mq.push_back(d);
    end
    m_pfull = (mq.size() >= THRESH);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0);
    aclr = 1'b1;
    @(posedge clk);
    #1;
    aclr = 1'b0;
    mq.delete();
    m_q_nr   = '0;
    m_pfull  = 1'b0;
    m_ovf    = 1'b0;
    just_rst = 1'b1;
  endtask

  initial begin
    int unsigned pw;
    int unsigned pr;
    int unsigned len;
    n_checks = 0;
    n_errors = 0;
    aclr     = 1'b1;
    drive(1'b0, 1'b0, '0);
    @(posedge clk);
    do_reset();
    cyc(1'b0, 1'b0, '0);

    // Fill with 1..256, one overflow attempt, then drain with rdreq held.
    for (int i = 1; i <= 256; i++) cyc(1'b1, 1'b0, WIDTH'(i));
    cyc(1'b1, 1'b0, 12'hABC);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    for (int i = 0; i < 256; i++) cyc(1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);

    // Simultaneous push/pop at count 1.
    cyc(1'b1, 1'b0, 12'h500);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, WIDTH'(12'h600 + i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);

    // Reset with 37 words stored.
    for (int i = 0; i < 37; i++) cyc(1'b1, 1'b0, WIDTH'($urandom));
    do_reset();
    cyc(1'b0, 1'b0, '0);

    // Randomized traffic in segments of varying write/read bias.
    for (int seg = 0; seg < 12; seg++) begin
      if (seg == 0) begin
        pw = 95; pr = 10; len = 400;
      end else if (seg == 1) begin
        pw = 10; pr = 95; len = 400;
      end else begin
        pw = $urandom_range(5, 95); pr = $urandom_range(5, 95); len = 200;
      end
      for (int i = 0; i < int'(len); i++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset();
        end else begin
          cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, WIDTH'($urandom));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcfifo.md
DCFIFO -- requirements
Module: dcfifo

Interface
REQ-001 Parameters:
- ENABLE_ECC, default "FALSE": accepted; has no effect; stored width stays LPM_WIDTH.
- INTENDED_DEVICE_FAMILY, default "Agilex": informational only.
- FIFO_TYPE, default "M20K": informational only ("M20K"/"MLAB"/"AUTO").
- LPM_NUM_WORDS, default 1024: depth; power of two, 4..131072.
- LPM_SHOWAHEAD, default "ON": "ON" = first-word-fall-through; "OFF" = normal read.
- LPM_TYPE, default "dcfifo": informational only.
- LPM_WIDTH, default 132: data width.
- LPM_THRESH, default 800: almost-full threshold, 1..LPM_NUM_WORDS-4.
- LPM_WIDTHU, default clog2(LPM_NUM_WORDS): usedw width.
- OVERFLOW_CHECKING, default "ON": block writes while full.
- UNDERFLOW_CHECKING, default "ON": block reads while empty.
- USE_EAB, default "ON": informational only.
- RDSYNC_DELAYPIPE, default 4: accepted; no effect, since there is a single clock.
- WRSYNC_DELAYPIPE, default 4: accepted; no effect.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all logic is clocked on its rising edge.
- aclr, in, 1: reset; synchronous, active-high.
- data, in, LPM_WIDTH: write data.
- wrreq, in, 1: write request.
- rdreq, in, 1: read request / acknowledge.
- q, out, LPM_WIDTH: read data.
- rdempty, out, 1: FIFO empty.
- wrempty, out, 1: identical to rdempty.
- wrfull, out, 1: FIFO full.
- rdfull, out, 1: identical to wrfull.
- wrpfull, out, 1: almost full, registered.
- wroverflow, out, 1: rejected-write pulse, registered.
- wrusedw, out, LPM_WIDTHU: stored word count.
- rdusedw, out, LPM_WIDTHU: identical to wrusedw.

Function
REQ-003 Internal count is LPM_WIDTHU+1 bits wide, range 0..LPM_NUM_WORDS.
- wrusedw/rdusedw = count modulo 2^LPM_WIDTHU, so they read 0 when full.
- wrfull/rdfull = (count == LPM_NUM_WORDS).
- rdempty/wrempty = (count == 0).
- All are combinational from registered state, so both views are identical and have zero latency.
REQ-004 Write is accepted when wrreq=1 and (not full or OVERFLOW_CHECKING="OFF"): data is stored at the write pointer, which then increments modulo depth.
REQ-005 Read is accepted when rdreq=1 and (not empty or UNDERFLOW_CHECKING="OFF"): the read pointer increments modulo depth.
REQ-006 Simultaneous accepted read and write leave count unchanged.
- When full with checking ON: the read is accepted and the write is rejected, because eligibility uses pre-edge flags.
- When empty with checking ON: the write is accepted and the read is rejected.
REQ-007 LPM_SHOWAHEAD="ON": q presents the head word whenever not empty, and rdreq pops it. The first written word appears on q no later than 2 clk after the write edge; rdempty deasserts only once q is valid.
REQ-008 LPM_SHOWAHEAD="OFF": q is updated with the head word 1 clk after an accepted read, and holds its value otherwise.
REQ-009 wrpfull is registered: 1 when next-cycle count >= LPM_THRESH.
REQ-010 wroverflow is a 1-clk pulse, registered, the cycle after a wrreq that arrived while full. It flags regardless of OVERFLOW_CHECKING.
REQ-011 With checking "OFF", overrun/underrun corrupts contents and count wraps; no recovery is required.

Reset
REQ-012 aclr=1 at a clk edge has priority over all requests and sets:
- pointers and count = 0;
- rdempty = wrempty = 1;
- wrfull = rdfull = wrpfull = wroverflow = 0;
- q = 0;
- usedw = 0.
REQ-013 Reset mid-operation discards all contents. Memory contents need not be cleared.

Configuration
REQ-014 Macro DCFIFO_ASSERT_EN: when defined, the design compiles simulation assertions that report $error on a write while full or a read while empty, and on count exceeding LPM_NUM_WORDS. When undefined, no assertion code is present and behaviour is otherwise identical.

Structure
REQ-015 Package dcfifo_pkg holds the "ON"/"OFF" and "TRUE"/"FALSE" string constants and the count-width helper function.
REQ-016 One sub-module, dcfifo_ram: a simple dual-port RAM, LPM_NUM_WORDS x LPM_WIDTH, with one write port and one registered read port.

Verification
REQ-017 After reset, write 256 words 1..256 in back-to-back cycles (LPM_NUM_WORDS=256, LPM_WIDTH=12, LPM_THRESH=100, showahead ON).
- wrpfull asserts the cycle after the 100th write.
- wrfull=1 after the 256th write, with wrusedw=0.
- rdempty=0 throughout.
REQ-018 With the FIFO full, assert wrreq with data=0xABC.
- wroverflow pulses 1 clk later.
- Count stays 256; 0xABC is never read out.
REQ-019 Drain the full FIFO with rdreq held high.
- q is 1..256 in order.
- rdempty=1 after the 256th pop.
- Further rdreq leaves count at 0.
REQ-020 With count=1, assert wrreq and rdreq together for 5 cycles: wrusedw stays 1 and the data order is preserved.
REQ-021 Assert aclr for 1 clk at count=37: next cycle shows rdempty=1, wrusedw=0, wrpfull=0, q=0.
REQ-022 Repeat REQ-017 and REQ-019 with showahead OFF: q lags rdreq by exactly 1 clk.
